// File: rtl/ext_mem_pkg.sv
// Shared types and default widths for the ext_mem responder.
package ext_mem_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_MEM_AW = 12;
   localparam int unsigned DEF_WAIT_W = 4;
   localparam int unsigned STAT_W     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

endpackage

// File: rtl/ext_mem_array.sv
// 1R1W synchronous word array; the backdoor write shares the array, and on
// an index collision the bus write lands last and wins.
module ext_mem_array
   import ext_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned MEM_AW = DEF_MEM_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_we,
   input  logic              bus_re,
   input  logic [MEM_AW-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_wdata,
   input  logic              bd_we,
   input  logic [MEM_AW-1:0] bd_addr,
   input  logic [DATA_W-1:0] bd_wdata,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 1 << MEM_AW;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   // Array storage is never reset.
   always_ff @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_wdata;
      end
      if (bus_we) begin
         mem[bus_addr] <= bus_wdata;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (bus_re) begin
         rd_data_d = mem[bus_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/ext_mem_responder.sv
// External-memory responder for the ext_mem bus with programmable wait states.
// Optional EXT_MEM_STATS_EN adds saturating completed-read/write counters.
module ext_mem_responder
   import ext_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned MEM_AW = DEF_MEM_AW,
   parameter int unsigned WAIT_W = DEF_WAIT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ext_mem_cs,
   input  logic              ext_mem_read,
   input  logic              ext_mem_write,
   input  logic [ADDR_W-1:0] ext_mem_addr,
   input  logic [DATA_W-1:0] ext_mem_wdata,
   output logic [DATA_W-1:0] ext_mem_rdata,
   output logic              ext_mem_ready,
   output logic              ext_mem_err,
   input  logic [WAIT_W-1:0] wait_cfg,
   input  logic              bd_we,
   input  logic [MEM_AW-1:0] bd_addr,
   input  logic [DATA_W-1:0] bd_wdata,
   output logic              busy
`ifdef EXT_MEM_STATS_EN
   ,
   output logic [STAT_W-1:0] rd_count,
   output logic [STAT_W-1:0] wr_count
`endif
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              mem_we_c, mem_re_c;

   // Upper address bits alias onto the array.
   if (MEM_AW < ADDR_W) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^ext_mem_addr[ADDR_W-1:MEM_AW];
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      mem_we_c = 1'b0;
      mem_re_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (ext_mem_cs && (ext_mem_read ^ ext_mem_write)) begin
               op_d    = ext_mem_write ? OP_WR : OP_RD;
               addr_d  = ext_mem_addr[MEM_AW-1:0];
               wdata_d = ext_mem_wdata;
               cnt_d   = wait_cfg;
               state_d = (wait_cfg == WAIT_W'(0)) ? RESP : WAIT;
            end else if (ext_mem_cs && ext_mem_read && ext_mem_write) begin
               err_d = 1'b1;
            end
         end
         WAIT: begin
            // Dropping cs abandons the access before anything commits.
            if (!ext_mem_cs) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - WAIT_W'(1);
               if (cnt_q == WAIT_W'(1)) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            mem_we_c = (op_q == OP_WR);
            mem_re_c = (op_q == OP_RD);
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE) || ready_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   ext_mem_array #(
      .DATA_W (DATA_W),
      .MEM_AW (MEM_AW)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_we    (mem_we_c),
      .bus_re    (mem_re_c),
      .bus_addr  (addr_q),
      .bus_wdata (wdata_q),
      .bd_we     (bd_we),
      .bd_addr   (bd_addr),
      .bd_wdata  (bd_wdata),
      .rd_data   (ext_mem_rdata)
   );

   assign ext_mem_ready = ready_q;
   assign ext_mem_err   = err_q;
   assign busy          = busy_q;

`ifdef EXT_MEM_STATS_EN
   logic [STAT_W-1:0] rd_count_q, rd_count_d;
   logic [STAT_W-1:0] wr_count_q, wr_count_d;

   // Count only completed accesses, saturating at all-ones.
   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (ready_d && (op_q == OP_RD) && (rd_count_q != '1)) begin
         rd_count_d = rd_count_q + STAT_W'(1);
      end
      if (ready_d && (op_q == OP_WR) && (wr_count_q != '1)) begin
         wr_count_d = wr_count_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ext_mem_responder.sv
// Scoreboard bench for ext_mem_responder: stimulus queues expected responses,
// a negedge monitor pops and compares every ready/err pulse.
module tb_ext_mem_responder;

   localparam int K_RD  = 0;
   localparam int K_WR  = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ext_mem_cs = 1'b0;
   logic        ext_mem_read = 1'b0;
   logic        ext_mem_write = 1'b0;
   logic [15:0] ext_mem_addr = '0;
   logic [7:0]  ext_mem_wdata = '0;
   logic [7:0]  ext_mem_rdata;
   logic        ext_mem_ready;
   logic        ext_mem_err;
   logic [3:0]  wait_cfg = '0;
   logic        bd_we = 1'b0;
   logic [11:0] bd_addr = '0;
   logic [7:0]  bd_wdata = '0;
   logic        busy;
`ifdef EXT_MEM_STATS_EN
   logic [31:0] rd_count;
   logic [31:0] wr_count;
`endif

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t expq[$];
   logic [7:0] last_rd = '0;

   ext_mem_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ext_mem_cs    (ext_mem_cs),
      .ext_mem_read  (ext_mem_read),
      .ext_mem_write (ext_mem_write),
      .ext_mem_addr  (ext_mem_addr),
      .ext_mem_wdata (ext_mem_wdata),
      .ext_mem_rdata (ext_mem_rdata),
      .ext_mem_ready (ext_mem_ready),
      .ext_mem_err   (ext_mem_err),
      .wait_cfg      (wait_cfg),
      .bd_we         (bd_we),
      .bd_addr       (bd_addr),
      .bd_wdata      (bd_wdata),
      .busy          (busy)
`ifdef EXT_MEM_STATS_EN
      ,
      .rd_count      (rd_count),
      .wr_count      (wr_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every ready/err pulse must match the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (ext_mem_ready || ext_mem_err)) begin
            total++;
            if (expq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_resp: ready=%0b err=%0b rdata=%02h cyc=%0d, want no response",
                        ext_mem_ready, ext_mem_err, ext_mem_rdata, cyc);
            end else begin
               e = expq.pop_front();
               if ((ext_mem_err != (e.kind == K_ERR)) || (ext_mem_ready != (e.kind != K_ERR)) ||
                   (cyc != e.cyc) || (ext_mem_rdata != e.data)) begin
                  bad++;
                  $display("FAIL resp: got ready=%0b err=%0b rdata=%02h cyc=%0d, want kind=%0d rdata=%02h cyc=%0d",
                           ext_mem_ready, ext_mem_err, ext_mem_rdata, cyc, e.kind, e.data, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bd_load(input logic [11:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_wdata = d;
      step();
      bd_we = 1'b0;
   endtask

   // Full access with cs held until the response state, then released.
   task automatic access(input logic rd, input logic [15:0] a, input logic [7:0] wd,
                         input int w, input logic [7:0] exp_rd);
      exp_t e;
      ext_mem_cs = 1'b1; ext_mem_read = rd; ext_mem_write = ~rd;
      ext_mem_addr = a; ext_mem_wdata = wd; wait_cfg = 4'(w);
      if (rd) last_rd = exp_rd;
      e.kind = rd ? K_RD : K_WR; e.data = last_rd; e.cyc = cyc + w + 2;
      expq.push_back(e);
      step();
      chk("busy_accept", 32'(busy), 32'd1);
      ext_mem_read = 1'b0; ext_mem_write = 1'b0; ext_mem_addr = '0; ext_mem_wdata = '0;
      for (int i = 0; i < w; i++) begin
         step();
         chk("busy_wait", 32'(busy), 32'd1);
      end
      ext_mem_cs = 1'b0;
      step();
      chk("busy_resp", 32'(busy), 32'd1);
      step();
      chk("busy_done", 32'(busy), 32'd0);
   endtask

   initial begin
      exp_t e;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {22'd0, ext_mem_rdata, ext_mem_ready, ext_mem_err, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Backdoor preload, zero-wait read with aliased high address bit.
      bd_load(12'h000, 8'h2A);
      access(1'b1, 16'h8000, 8'h00, 0, 8'h2A);

      // Three wait states each way.
      access(1'b0, 16'h0010, 8'h5A, 3, 8'h00);
      access(1'b1, 16'h0010, 8'h00, 3, 8'h5A);

      // Aliasing above MEM_AW.
      access(1'b0, 16'h1004, 8'h77, 0, 8'h00);
      access(1'b1, 16'h0004, 8'h00, 0, 8'h77);

      // Back-to-back reads with the request held through the ready cycle.
      bd_load(12'h030, 8'h01);
      bd_load(12'h031, 8'h02);
      ext_mem_cs = 1'b1; ext_mem_read = 1'b1; ext_mem_addr = 16'h0030; wait_cfg = 4'd0;
      e.kind = K_RD; e.data = 8'h01; e.cyc = cyc + 2; expq.push_back(e);
      step();
      step();
      ext_mem_addr = 16'h0031;
      e.kind = K_RD; e.data = 8'h02; e.cyc = cyc + 2; expq.push_back(e);
      step();
      ext_mem_cs = 1'b0; ext_mem_read = 1'b0;
      last_rd = 8'h02;
      repeat (3) step();

      // Protocol error: read and write together.
      bd_load(12'h040, 8'h5C);
      ext_mem_cs = 1'b1; ext_mem_read = 1'b1; ext_mem_write = 1'b1;
      ext_mem_addr = 16'h0040; ext_mem_wdata = 8'hFF;
      e.kind = K_ERR; e.data = last_rd; e.cyc = cyc + 1; expq.push_back(e);
      step();
      ext_mem_cs = 1'b0; ext_mem_read = 1'b0; ext_mem_write = 1'b0;
      chk("busy_after_err", 32'(busy), 32'd0);
      repeat (2) step();
      access(1'b1, 16'h0040, 8'h00, 0, 8'h5C);

      // Abort: cs drops two cycles into a five-wait write.
      bd_load(12'h050, 8'h66);
      ext_mem_cs = 1'b1; ext_mem_write = 1'b1; ext_mem_addr = 16'h0050;
      ext_mem_wdata = 8'h99; wait_cfg = 4'd5;
      step();
      step();
      step();
      ext_mem_cs = 1'b0; ext_mem_write = 1'b0;
      step();
      chk("busy_after_abort", 32'(busy), 32'd0);
      repeat (8) step();
      access(1'b1, 16'h0050, 8'h00, 0, 8'h66);

      // Backdoor and bus write to the same index on the commit edge.
      ext_mem_cs = 1'b1; ext_mem_write = 1'b1; ext_mem_addr = 16'h0020;
      ext_mem_wdata = 8'h22; wait_cfg = 4'd0;
      e.kind = K_WR; e.data = last_rd; e.cyc = cyc + 2; expq.push_back(e);
      step();
      ext_mem_cs = 1'b0; ext_mem_write = 1'b0;
      bd_we = 1'b1; bd_addr = 12'h020; bd_wdata = 8'h11;
      step();
      bd_we = 1'b0;
      repeat (2) step();
      access(1'b1, 16'h0020, 8'h00, 0, 8'h22);

      // Reset in the middle of a waited write.
      bd_load(12'h060, 8'h44);
      ext_mem_cs = 1'b1; ext_mem_write = 1'b1; ext_mem_addr = 16'h0060;
      ext_mem_wdata = 8'hAB; wait_cfg = 4'd5;
      step();
      step();
      rst_n = 1'b0;
      ext_mem_cs = 1'b0; ext_mem_write = 1'b0;
      #1;
      chk("reset_mid_wait", {22'd0, ext_mem_rdata, ext_mem_ready, ext_mem_err, busy}, 32'd0);
`ifdef EXT_MEM_STATS_EN
      chk("rd_count_reset", rd_count, 32'd0);
      chk("wr_count_reset", wr_count, 32'd0);
`endif
      last_rd = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // From here: 3 reads, 2 writes, 1 error, 1 abort.
      access(1'b1, 16'h0060, 8'h00, 0, 8'h44);
      access(1'b0, 16'h0070, 8'h12, 1, 8'h00);
      access(1'b1, 16'h0070, 8'h00, 2, 8'h12);
      access(1'b0, 16'h0071, 8'h34, 2, 8'h00);
      ext_mem_cs = 1'b1; ext_mem_read = 1'b1; ext_mem_write = 1'b1; ext_mem_addr = 16'h0071;
      e.kind = K_ERR; e.data = last_rd; e.cyc = cyc + 1; expq.push_back(e);
      step();
      ext_mem_cs = 1'b0; ext_mem_read = 1'b0; ext_mem_write = 1'b0;
      step();
      ext_mem_cs = 1'b1; ext_mem_write = 1'b1; ext_mem_addr = 16'h0071;
      ext_mem_wdata = 8'hEE; wait_cfg = 4'd4;
      step();
      step();
      ext_mem_cs = 1'b0; ext_mem_write = 1'b0;
      repeat (6) step();
      access(1'b1, 16'h0071, 8'h00, 0, 8'h34);
`ifdef EXT_MEM_STATS_EN
      chk("rd_count", rd_count, 32'd3);
      chk("wr_count", wr_count, 32'd2);
`endif

      repeat (4) step();
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
